alu_issue_seq: RTL and testbench

Issue sequencer placed directly upstream of the 9-bit, 16-opcode combinational ALU. Accepts register-to-register instructions over a valid/ready handshake and reads operands from a small internal register file. Drives the ALU's `a`/`b`/`s` inputs from registers, captures the ALU result one cycle later, and writes it back, reporting each write on a one-cycle writeback strobe. It traps divide/modulo by zero so the ALU's undefined result never reaches the register file.

---
 rtl/alu_issue_seq.sv | 143 ++++++++++++++
 tb/tb_alu_issue_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Issue sequencer for the 9-bit, 16-opcode combinational ALU.
// Serializes register-to-register instructions through IDLE -> EXEC -> WB.
// It reads operands from an internal register file and registers the ALU inputs.
// It captures the ALU result after one full cycle and writes it back.
// Divide/modulo by zero is trapped to an all-ones result.
module alu_issue_seq #(
  parameter int DW   = 9,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_s,
  input  logic [DW-1:0] alu_out,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          div0_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_rf [NREG];
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [3:0]    r_alu_s;
  logic [AW-1:0] r_rd;
  logic          r_div0;
  logic [DW-1:0] r_result;
  logic [DW-1:0] w_rs1_data;
  logic [DW-1:0] w_rs2_data;
  logic          w_accept;

  // Opcodes that take only operand A; B is forced to zero for these.
  function automatic logic is_unary(input logic [3:0] op);
    case (op)
      4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Divide or modulo with a zero divisor has no defined ALU result.
  function automatic logic is_div0(input logic [3:0] op, input logic [DW-1:0] b);
    return ((op == 4'b0011) || (op == 4'b0100)) && (b == '0);
  endfunction

  // Replace an undefined quotient/remainder with all ones.
  function automatic logic [DW-1:0] trap_result(input logic div0, input logic [DW-1:0] res);
    return div0 ? '1 : res;
  endfunction

  assign w_rs1_data = r_rf[instr_rs1];
  assign w_rs2_data = r_rf[instr_rs2];
  assign w_accept   = instr_valid && instr_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: fixed three-cycle sequence once an instruction is accepted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: handshake and writeback strobes depend on state only.
  always_comb begin
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    div0_err    = 1'b0;
    case (r_state)
      S_IDLE: instr_ready = 1'b1;
      S_WB: begin
        wb_valid = 1'b1;
        div0_err = r_div0;
      end
      default: ;
    endcase
  end

  // Operand/opcode registers and latched rd/div0, loaded only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_s <= '0;
      r_rd    <= '0;
      r_div0  <= 1'b0;
    end else if (w_accept) begin
      r_alu_a <= w_rs1_data;
      r_alu_b <= is_unary(instr_op) ? '0 : w_rs2_data;
      r_alu_s <= instr_op;
      r_rd    <= instr_rd;
      r_div0  <= is_div0(instr_op, w_rs2_data);
    end
  end

  // Result capture at the end of EXEC, after a full cycle through the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_result <= '0;
    else if (r_state == S_EXEC) r_result <= trap_result(r_div0, alu_out);
  end

  // Register file: preload in any state; the writeback is last, so it wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      if (ld_en)             r_rf[ld_addr] <= ld_data;
      if (r_state == S_WB)   r_rf[r_rd]    <= r_result;
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_s    = r_alu_s;
  assign wb_rd    = r_rd;
  assign wb_data  = r_result;
  assign dbg_data = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed testbench for alu_issue_seq with a small behavioural ALU attached.
module tb_alu_issue_seq;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [2:0] instr_rd;
  logic [2:0] instr_rs1;
  logic [2:0] instr_rs2;
  logic [8:0] alu_a;
  logic [8:0] alu_b;
  logic [3:0] alu_s;
  logic [8:0] alu_out;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [8:0] ld_data;
  logic [2:0] dbg_addr;
  logic [8:0] dbg_data;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [8:0] wb_data;
  logic       div0_err;

  int checks   = 0;
  int failures = 0;

  alu_issue_seq #(.DW(9), .NREG(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .div0_err(div0_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; div/mod by zero return junk that must never reach the register file.
  always_comb begin
    alu_out = alu_a ^ alu_b;
    case (alu_s)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0001: alu_out = alu_a - alu_b;
      4'b0011: alu_out = (alu_b == 0) ? 9'h0AA : alu_a / alu_b;
      4'b0100: alu_out = (alu_b == 0) ? 9'h055 : alu_a % alu_b;
      4'b1100: alu_out = alu_a << 1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [8:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rf_chk(input logic [2:0] a, input logic [8:0] exp, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Issue one instruction from IDLE (at a negedge) and check every cycle of it.
  // An optional preload is driven during the WB cycle.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [8:0] ea, input logic [8:0] eb,
                       input logic [8:0] eres, input logic ediv, input logic le,
                       input logic [2:0] la, input logic [8:0] ldd, input string tag);
    chk({tag, ".ready_c0"}, instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_c1"}, instr_ready, 0);
    chk({tag, ".wbv_c1"}, wb_valid, 0);
    chk({tag, ".alu_a"}, alu_a, ea);
    chk({tag, ".alu_b"}, alu_b, eb);
    chk({tag, ".alu_s"}, alu_s, op);
    @(negedge clk);
    chk({tag, ".wbv_c2"}, wb_valid, 1);
    chk({tag, ".wb_rd"}, wb_rd, rd);
    chk({tag, ".wb_data"}, wb_data, eres);
    chk({tag, ".div0"}, div0_err, ediv);
    ld_en = le; ld_addr = la; ld_data = ldd;
    @(negedge clk);
    ld_en = 1'b0;
    chk({tag, ".wbv_c3"}, wb_valid, 0);
    chk({tag, ".div0_c3"}, div0_err, 0);
    chk({tag, ".ready_c3"}, instr_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
    instr_rs1 = '0; instr_rs2 = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst.wb_valid", wb_valid, 0);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_s", alu_s, 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.div0", div0_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", instr_ready, 1);
    rf_chk(3'd1, 9'd0, "rst.r1");

    // Add: 20 + 7 = 27 into r3.
    preload(3'd1, 9'd20);
    preload(3'd2, 9'd7);
    rf_chk(3'd1, 9'd20, "pre.r1");
    issue(4'b0000, 3'd3, 3'd1, 3'd2, 9'd20, 9'd7, 9'd27, 1'b0, 1'b0, 3'd0, 9'd0, "add");
    rf_chk(3'd3, 9'd27, "add.r3");

    // Sub: 7 - 20 wraps to 0x1F3.
    issue(4'b0001, 3'd4, 3'd2, 3'd1, 9'd7, 9'd20, 9'h1F3, 1'b0, 1'b0, 3'd0, 9'd0, "sub");
    rf_chk(3'd4, 9'h1F3, "sub.r4");

    // Unary shift: alu_b forced to 0 even though rs2 holds 7.
    issue(4'b1100, 3'd7, 3'd1, 3'd2, 9'd20, 9'd0, 9'd40, 1'b0, 1'b0, 3'd0, 9'd0, "shl");
    rf_chk(3'd7, 9'd40, "shl.r7");

    // Divide and modulo by zero trap to all ones.
    preload(3'd5, 9'd0);
    issue(4'b0011, 3'd6, 3'd1, 3'd5, 9'd20, 9'd0, 9'h1FF, 1'b1, 1'b0, 3'd0, 9'd0, "div0");
    rf_chk(3'd6, 9'h1FF, "div0.r6");
    preload(3'd6, 9'd0);
    issue(4'b0100, 3'd6, 3'd1, 3'd5, 9'd20, 9'd0, 9'h1FF, 1'b1, 1'b0, 3'd0, 9'd0, "mod0");
    rf_chk(3'd6, 9'h1FF, "mod0.r6");
    // Ordinary divide: 20 / 7 = 2, no trap.
    issue(4'b0011, 3'd7, 3'd1, 3'd2, 9'd20, 9'd7, 9'd2, 1'b0, 1'b0, 3'd0, 9'd0, "div");

    // Back-to-back with valid held: r1 = 20+7 = 27, then r2 = r1+r1 = 54.
    instr_valid = 1'b1; instr_op = 4'b0000; instr_rd = 3'd1; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    @(posedge clk); #1;
    instr_rd = 3'd2; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    @(negedge clk);
    chk("b2b.ready_c1", instr_ready, 0);
    @(negedge clk);
    chk("b2b.ready_c2", instr_ready, 0);
    chk("b2b.wb1", wb_data, 9'd27);
    @(negedge clk);
    chk("b2b.ready_c3", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b.alu_a2", alu_a, 9'd27);
    chk("b2b.alu_b2", alu_b, 9'd27);
    @(negedge clk);
    chk("b2b.wbv2", wb_valid, 1);
    chk("b2b.wb_rd2", wb_rd, 3'd2);
    chk("b2b.wb2", wb_data, 9'd54);
    @(negedge clk);
    rf_chk(3'd2, 9'd54, "b2b.r2");

    // Preload collides with writeback to r3: writeback wins.
    issue(4'b0000, 3'd3, 3'd1, 3'd0, 9'd27, 9'd0, 9'd27, 1'b0, 1'b1, 3'd3, 9'h055, "coll");
    rf_chk(3'd3, 9'd27, "coll.r3");
    // Preload to a different register during writeback: both land.
    issue(4'b0000, 3'd4, 3'd1, 3'd0, 9'd27, 9'd0, 9'd27, 1'b0, 1'b1, 3'd5, 9'h0AB, "both");
    rf_chk(3'd4, 9'd27, "both.r4");
    rf_chk(3'd5, 9'h0AB, "both.r5");

    // Reset during EXEC aborts the instruction.
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'b0000; instr_rd = 3'd6; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid.alu_a_pre", alu_a, 9'd27);
    rst_n = 1'b0;
    #1;
    chk("mid.alu_a", alu_a, 0);
    chk("mid.wbv", wb_valid, 0);
    chk("mid.ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mid.nowb%0d", c), wb_valid, 0);
    end
    chk("mid.ready_post", instr_ready, 1);
    for (int r = 0; r < 8; r++) rf_chk(r[2:0], 9'd0, $sformatf("mid.r%0d", r));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
